leg_solver: RTL and testbench
=============================

# leg_solver

Iterative right-triangle leg solver: given hypotenuse `c` and one leg `a` (unsigned 8-bit), computes the other leg `b = sqrt(c² − a²)` using shift-add squaring and digit-by-digit square root. No multipliers are used. It is the inverse of the team's hypotenuse datapath and sits beside it as a multi-cycle coprocessor with a start/done handshake. Latency is fixed at 26 cycles, which keeps area small enough for a Tiny Tapeout tile.

## Interface

Parameters:
- none (widths fixed at 8-bit operands, 16-bit internal squares)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset; asynchronous, active-low
- `start`  in  1  request; sampled only in IDLE
- `c_in`  in  8  hypotenuse; captured on the acceptance edge
- `a_in`  in  8  known leg; captured on the acceptance edge
- `busy`  out  1  high from the acceptance edge until done rises
- `done`  out  1  one-cycle pulse; result valid
- `b_out`  out  8  result leg; held until the next acceptance
- `err`  out  1  high when `a > c`; held with `b_out`

## Operation

- States: IDLE → SQ_C (8 cycles) → SQ_A (8 cycles) → SUB (1 cycle) → ROOT (8 cycles) → DONE (1 cycle) → IDLE.
- **IDLE**
  - When `start` = 1, latch `c_in`/`a_in`, set `busy` = 1, clear the 16-bit accumulator and the bit counter, then go to SQ_C.
  - `b_out`/`err` keep their previous values.
- **SQ_C / SQ_A** (shift-add square)
  - Iteration `j` = 0..7: if `x[j]`, then `acc += x << j` (16-bit).
  - Results are `c2` and `a2`, each ≤ 65025, so there is no overflow.
- **SUB**
  - If `a2 > c2`: set the error flag and `diff` = 0.
  - Otherwise `diff = c2 − a2` (16-bit).
- **ROOT** (restoring digit-by-digit square root, one result bit per cycle, MSB first)
  - Each step: `rem = (rem << 2) | next two diff bits`; `trial = (root << 2) | 1`.
  - If `rem ≥ trial`: `rem −= trial`, `root = (root << 1) | 1`; else `root <<= 1`.
  - `rem` is 10 bits wide. The result is `floor(sqrt(diff))`.
- **DONE**
  - Update `b_out` and `err`, pulse `done`, clear `busy`, return to IDLE.
  - If the error flag is set, `b_out` = 0.
- Constant latency: the error case still runs all states.
- `start` outside IDLE is ignored, including during the DONE cycle. It is not queued.

## Timing

- Reset: state = IDLE; `busy` = 0, `done` = 0, `b_out` = 0x00, `err` = 0; all internal registers = 0.
- Reset asserted mid-operation aborts immediately. No `done` is produced. The first edge after release is an IDLE edge.
- Acceptance edge E0 (IDLE, `start` = 1): `busy` rises after E0.
- Schedule relative to E0:
  - SQ_C occupies E1–E8.
  - SQ_A occupies E9–E16.
  - SUB occurs at E17.
  - ROOT occupies E18–E25.
  - At E26: `b_out`/`err` update, `done` = 1, `busy` = 0.
  - At E27: `done` = 0, state = IDLE.
- Back-to-back operation: `start` held high is next accepted at E27, giving a 27-cycle issue interval.
- `c_in`/`a_in` may change freely after E0.
- Boundaries:
  - `a = c` → `b` = 0, `err` = 0.
  - `a = 0` → `b = c`.
  - `c = 0, a > 0` → `err` = 1.
  - `c = 255, a = 0` → `diff` = 65025, `b` = 255.

## Configuration

- Macro: `LEG_SOLVER_ROUND_EN`.
- Defined: at DONE, with floor root `r` and remainder `rem = diff − r²` (already in the `rem` register), output `r + 1` when `rem > r`, saturated at 255. This rounds to nearest with ties impossible for integers. Latency is unchanged and `err` behaviour is unchanged.
- Undefined: `b_out = floor(sqrt(diff))`. No rounding logic is synthesized.

## Test plan

- Reset, then `c`=5, `a`=3, `start` for 1 cycle → `busy` for 26 cycles, `done` pulse at E26, `b_out` = 4, `err` = 0; `b_out` holds 4 afterwards.
- `c`=255, `a`=0 → `b_out` = 255; `c`=10, `a`=10 → `b_out` = 0, `err` = 0.
- `c`=5, `a`=7 → `err` = 1, `b_out` = 0, `done` still at E26. Next run `c`=13, `a`=5 → `err` = 0, `b_out` = 12.
- `c`=3, `a`=1 (`diff` = 8) → `b_out` = 2 without `LEG_SOLVER_ROUND_EN`, 3 with it. `c`=10, `a`=7 (`diff` = 51) → 7 in both builds.
- `start` held high continuously, operands changed at E1 → second acceptance at E27. First result reflects the operands latched at E0. `start` pulses at E5 and E26 are ignored.
- `rst_n` low at E12 of a run → outputs 0 asynchronously, no `done`. A new `start` after release completes normally with correct `b_out`.

Source files
------------

// File: rtl/leg_solver.sv
// Multi-cycle right-triangle leg solver: b = sqrt(c^2 - a^2) using shift-add squares and a restoring root.
// Optional build macro LEG_SOLVER_ROUND_EN rounds the root to nearest instead of flooring.
module leg_solver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] c_in,
    input  logic [7:0] a_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] b_out,
    output logic       err
);

    typedef enum logic [2:0] {IDLE, SQ_C, SQ_A, SUB, ROOT, DONE} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [7:0]  c_reg;
    logic [7:0]  a_reg;
    logic [15:0] acc;
    logic [15:0] c2;
    logic [15:0] diff;
    logic [9:0]  rem;
    logic [7:0]  root;
    logic        err_flag;

    logic [7:0]  sq_src;
    logic [15:0] acc_next;
    logic [9:0]  rem_sh;
    logic [9:0]  trial;
    logic        root_fit;

`ifdef LEG_SOLVER_ROUND_EN
    // The remainder is diff - r^2; exceeding r means diff sits past (r + 0.5)^2.
    function automatic logic [7:0] round_root(input logic [7:0] r, input logic [9:0] rm);
        if ((rm > {2'b00, r}) && (r != 8'hFF))
            return r + 8'd1;
        return r;
    endfunction
`endif

    always_comb begin
        sq_src   = (state == SQ_C) ? c_reg : a_reg;
        acc_next = sq_src[cnt] ? (acc + ({8'd0, sq_src} << cnt)) : acc;
        // Remainder never exceeds 2*root (<= 254) before the shift, so its top bits can be dropped.
        rem_sh   = {rem[7:0], diff[15:14]};
        trial    = {root, 2'b01};
        root_fit = (rem_sh >= trial);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            c_reg    <= 8'd0;
            a_reg    <= 8'd0;
            acc      <= 16'd0;
            c2       <= 16'd0;
            diff     <= 16'd0;
            rem      <= 10'd0;
            root     <= 8'd0;
            err_flag <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            b_out    <= 8'd0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        c_reg    <= c_in;
                        a_reg    <= a_in;
                        acc      <= 16'd0;
                        cnt      <= 3'd0;
                        err_flag <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SQ_C;
                    end
                end
                SQ_C: begin
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        c2    <= acc_next;
                        acc   <= 16'd0;
                        state <= SQ_A;
                    end else begin
                        acc <= acc_next;
                    end
                end
                SQ_A: begin
                    // acc is left holding a^2 for the subtract step.
                    cnt <= cnt + 3'd1;
                    acc <= acc_next;
                    if (cnt == 3'd7)
                        state <= SUB;
                end
                SUB: begin
                    if (acc > c2) begin
                        err_flag <= 1'b1;
                        diff     <= 16'd0;
                    end else begin
                        diff <= c2 - acc;
                    end
                    rem   <= 10'd0;
                    root  <= 8'd0;
                    cnt   <= 3'd0;
                    state <= ROOT;
                end
                ROOT: begin
                    diff <= {diff[13:0], 2'b00};
                    rem  <= root_fit ? (rem_sh - trial) : rem_sh;
                    root <= {root[6:0], root_fit};
                    cnt  <= cnt + 3'd1;
                    if (cnt == 3'd7)
                        state <= DONE;
                end
                DONE: begin
`ifdef LEG_SOLVER_ROUND_EN
                    b_out <= err_flag ? 8'd0 : round_root(root, rem);
`else
                    b_out <= err_flag ? 8'd0 : root;
`endif
                    err   <= err_flag;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_leg_solver.sv
// Directed bench for leg_solver: latency, results, error flag, handshake corner cases and reset abort.
// Expectations for non-square differences follow LEG_SOLVER_ROUND_EN.
module tb_leg_solver;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] c_in;
    logic [7:0] a_in;
    logic       busy;
    logic       done;
    logic [7:0] b_out;
    logic       err;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] last_b;

`ifdef LEG_SOLVER_ROUND_EN
    localparam logic [7:0] EXP_3_1     = 8'd3;
    localparam logic [7:0] EXP_255_254 = 8'd23;
`else
    localparam logic [7:0] EXP_3_1     = 8'd2;
    localparam logic [7:0] EXP_255_254 = 8'd22;
`endif

    leg_solver dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .c_in  (c_in),
        .a_in  (a_in),
        .busy  (busy),
        .done  (done),
        .b_out (b_out),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // One operation with a single-cycle start; operands are scrambled right after acceptance.
    task automatic run_op(input string tag, input logic [7:0] c, input logic [7:0] a,
                          input logic [7:0] eb, input logic ee);
        int n;
        int blo;
        @(negedge clk);
        c_in = c; a_in = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0; c_in = ~c; a_in = ~a;
        check({tag, "_busy0"}, int'(busy), 1);
        check({tag, "_hold"}, int'(b_out), int'(last_b));
        n = 0; blo = 0;
        while (!done && n < 40) begin
            if (!busy) blo++;
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, n, 26);
        check({tag, "_busylo"}, blo, 0);
        check({tag, "_b"}, int'(b_out), int'(eb));
        check({tag, "_err"}, int'(err), int'(ee));
        check({tag, "_busy26"}, int'(busy), 0);
        @(negedge clk);
        check({tag, "_done27"}, int'(done), 0);
        check({tag, "_bheld"}, int'(b_out), int'(eb));
        check({tag, "_idle27"}, int'(busy), 0);
        last_b = eb;
    endtask

    initial begin
        int n;
        int dcount;
        rst_n = 1'b0; start = 1'b0; c_in = 8'd0; a_in = 8'd0; last_b = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_b", int'(b_out), 0);
        check("rst_err", int'(err), 0);
        rst_n = 1'b1;

        run_op("c5a3", 8'd5, 8'd3, 8'd4, 1'b0);
        run_op("c255a0", 8'd255, 8'd0, 8'd255, 1'b0);
        run_op("c10a10", 8'd10, 8'd10, 8'd0, 1'b0);
        run_op("c5a7", 8'd5, 8'd7, 8'd0, 1'b1);
        run_op("c13a5", 8'd13, 8'd5, 8'd12, 1'b0);
        run_op("c3a1", 8'd3, 8'd1, EXP_3_1, 1'b0);
        run_op("c10a7", 8'd10, 8'd7, 8'd7, 1'b0);
        run_op("c0a5", 8'd0, 8'd5, 8'd0, 1'b1);
        run_op("c1a0", 8'd1, 8'd0, 8'd1, 1'b0);
        run_op("c200a120", 8'd200, 8'd120, 8'd160, 1'b0);

        // start held high: second acceptance at E27 with operands changed at E1
        @(negedge clk);
        c_in = 8'd13; a_in = 8'd5; start = 1'b1;
        @(negedge clk);
        c_in = 8'd5; a_in = 8'd3;
        n = 0;
        while (!done && n < 40) begin @(negedge clk); n++; end
        check("b2b_lat1", n, 26);
        check("b2b_b1", int'(b_out), 12);
        @(negedge clk);
        n++;
        start = 1'b0;
        check("b2b_reacc", int'(busy), 1);
        check("b2b_done27", int'(done), 0);
        while (!done && n < 80) begin @(negedge clk); n++; end
        check("b2b_lat2", n, 53);
        check("b2b_b2", int'(b_out), 4);
        @(negedge clk);
        last_b = 8'd4;

        // start pulses at E5 (with new operands) and E26 must be ignored
        @(negedge clk);
        c_in = 8'd255; a_in = 8'd254; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            if (n == 4) begin start = 1'b1; c_in = 8'd1; a_in = 8'd0; end
            if (n == 5) start = 1'b0;
            if (n == 25) start = 1'b1;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check("ign_lat", n, 26);
        check("ign_b", int'(b_out), int'(EXP_255_254));
        @(negedge clk);
        check("ign_busy27", int'(busy), 0);
        check("ign_done27", int'(done), 0);
        last_b = EXP_255_254;

        // reset asserted around E12 aborts the run
        @(negedge clk);
        c_in = 8'd200; a_in = 8'd120; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_b", int'(b_out), 0);
        check("abort_err", int'(err), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("abort_nodone", dcount, 0);
        last_b = 8'd0;
        run_op("post_rst", 8'd200, 8'd120, 8'd160, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
